// File: rtl/pulse_len_detector_if.sv
// rtl/pulse_len_detector_if.sv - bundled stimulus/result signals of the pulse-length detector
interface pulse_len_detector_if #(
    parameter int CH = 4,
    parameter int CW = 5
);
    logic [CH-1:0]    a;
    logic             mode;
    logic [CW-1:0]    lo;
    logic [CW-1:0]    hi;
    logic             clr;
    logic [CH-1:0]    s;
    logic [CH-1:0]    ovf;
    logic [CH*CW-1:0] len_o;

    modport master (
        output a, mode, lo, hi, clr,
        input  s, ovf, len_o
    );

    modport slave (
        input  a, mode, lo, hi, clr,
        output s, ovf, len_o
    );
endinterface

// File: rtl/pulse_len_detector.sv
// rtl/pulse_len_detector.sv - multi-channel pulse-length window strobe / debouncer
module pulse_len_detector #(
    parameter int CH = 4,
    parameter int CW = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    pulse_len_detector_if.slave  bus
);
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};
    localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_SAT
    } state_t;

    state_t        state_q [CH];
    state_t        state_d [CH];
    logic [CW-1:0] cnt_q   [CH];
    logic [CW-1:0] cnt_d   [CH];
    logic [CW-1:0] len_q   [CH];
    logic [CW-1:0] len_d   [CH];
    logic [CH-1:0] sat_q, sat_d;
    logic [CH-1:0] s_q, s_d;
    logic [CH-1:0] ovf_q, ovf_d;
    logic [CH-1:0] ovf_set;
    logic          mode_q, mode_d;
    logic          mode_chg;
    logic [CW-1:0] lo_eff;

    always_comb begin
        mode_d   = bus.mode;
        mode_chg = (bus.mode != mode_q);
        // A zero lower bound would accept nothing new: every pulse is at least one sample.
        lo_eff   = (bus.lo == '0) ? ONE : bus.lo;
        ovf_set  = '0;
        sat_d    = sat_q;
        s_d      = s_q;
        for (int i = 0; i < CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            len_d[i]   = len_q[i];
            if (mode_chg) begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = '0;
                sat_d[i]   = 1'b0;
                s_d[i]     = 1'b0;
            end else if (bus.a[i]) begin
                if (cnt_q[i] == CMAX) begin
                    cnt_d[i]   = cnt_q[i];
                    sat_d[i]   = 1'b1;
                    ovf_set[i] = 1'b1;
                    state_d[i] = ST_SAT;
                end else begin
                    cnt_d[i]   = cnt_q[i] + ONE;
                    state_d[i] = (cnt_d[i] == CMAX) ? ST_SAT : ST_RUN;
                end
                // Debounce level latches once the threshold is reached and holds through SAT.
                s_d[i] = mode_q ? (s_q[i] | (cnt_d[i] == lo_eff)) : 1'b0;
            end else begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = '0;
                sat_d[i]   = 1'b0;
                s_d[i]     = 1'b0;
                if (state_q[i] != ST_IDLE) begin
                    len_d[i] = cnt_q[i];
                    if (!mode_q) begin
                        s_d[i] = !sat_q[i] && (cnt_q[i] >= lo_eff) && (cnt_q[i] <= bus.hi);
                    end
                end
            end
        end
        // A new overflow wins over a simultaneous clear.
        ovf_d = ovf_set | (ovf_q & ~{CH{bus.clr}});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 1'b0;
            sat_q  <= '0;
            s_q    <= '0;
            ovf_q  <= '0;
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
                len_q[i]   <= '0;
            end
        end else begin
            mode_q <= mode_d;
            sat_q  <= sat_d;
            s_q    <= s_d;
            ovf_q  <= ovf_d;
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                len_q[i]   <= len_d[i];
            end
        end
    end

    always_comb begin
        bus.s   = s_q;
        bus.ovf = ovf_q;
        for (int i = 0; i < CH; i++) begin
            bus.len_o[i*CW +: CW] = len_q[i];
        end
    end
endmodule

// File: tb/tb_pulse_len_detector.sv
// tb/tb_pulse_len_detector.sv - directed self-checking bench for pulse_len_detector
module tb_pulse_len_detector;
    localparam int CH = 4;
    localparam int CW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    pulse_len_detector_if #(.CH(CH), .CW(CW)) bus ();

    pulse_len_detector #(.CH(CH), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] len_of(input int ch);
        return 32'(bus.len_o[ch*CW +: CW]);
    endfunction

    // Holds channel ch high for n samples, then samples it low once.
    task automatic pulse(input int ch, input int n);
        bus.a[ch] = 1'b1;
        repeat (n) tick();
        bus.a[ch] = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.a    = '0;
        bus.mode = 1'b0;
        bus.lo   = 5'd3;
        bus.hi   = 5'd6;
        bus.clr  = 1'b0;
        #3;
        chk("rst_s", 32'(bus.s), 0);
        chk("rst_ovf", 32'(bus.ovf), 0);
        chk("rst_len", 32'(bus.len_o), 0);
        rst = 1'b0;
        tick();

        // In-window pulse of 4 on channel 0
        bus.a[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t1_s_high", 32'(bus.s), 0);
        end
        bus.a[0] = 1'b0;
        tick();
        chk("t1_strobe", 32'(bus.s), 32'h1);
        chk("t1_len0", len_of(0), 4);
        tick();
        chk("t1_one_cycle", 32'(bus.s), 0);

        // Out-of-window pulses, then both inclusive boundaries
        pulse(1, 2);
        chk("t2_short_s", 32'(bus.s), 0);
        chk("t2_len1", len_of(1), 2);
        pulse(2, 7);
        chk("t2_long_s", 32'(bus.s), 0);
        chk("t2_len2", len_of(2), 7);
        pulse(3, 6);
        chk("t2_hi_incl", 32'(bus.s), 32'h8);
        tick();
        chk("t2_hi_drop", 32'(bus.s), 0);
        pulse(3, 3);
        chk("t2_lo_incl", 32'(bus.s), 32'h8);

        // One-cycle gap ends the first pulse and restarts the count
        bus.a[0] = 1'b1;
        repeat (3) tick();
        bus.a[0] = 1'b0;
        tick();
        chk("gap_strobe1", 32'(bus.s), 32'h1);
        chk("gap_len1", len_of(0), 3);
        pulse(0, 4);
        chk("gap_strobe2", 32'(bus.s), 32'h1);
        chk("gap_len2", len_of(0), 4);

        // Saturation and overflow with hi at CMAX
        bus.hi = 5'd31;
        bus.a[0] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 31) chk("t3_ovf_31", 32'(bus.ovf), 0);
            if (k == 32) chk("t3_ovf_32", 32'(bus.ovf), 32'h1);
        end
        bus.a[0] = 1'b0;
        tick();
        chk("t3_sat_no_strobe", 32'(bus.s), 0);
        chk("t3_len0", len_of(0), 31);
        chk("t3_ovf_sticky", 32'(bus.ovf), 32'h1);
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        chk("t3_clr", 32'(bus.ovf), 0);
        bus.a[0] = 1'b1;
        repeat (31) tick();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        chk("t3_set_over_clr", 32'(bus.ovf), 32'h1);
        bus.a[0] = 1'b0;
        tick();

        // Debounce mode: bounce must not raise s
        bus.hi = 5'd6;
        bus.mode = 1'b1;
        bus.lo = 5'd4;
        tick();
        chk("t4_modechg_s", 32'(bus.s), 0);
        begin
            logic [8:0] seq_a;
            logic [8:0] seq_s;
            seq_a = 9'b011111011;
            seq_s = 9'b011000000;
            for (int k = 0; k < 9; k++) begin
                bus.a[0] = seq_a[k];
                tick();
                chk($sformatf("t4_s_%0d", k), 32'(bus.s[0]), 32'(seq_s[k]));
                if (k == 2) chk("t4_len_bounce", len_of(0), 2);
            end
        end
        chk("t4_len_final", len_of(0), 5);

        // Asynchronous reset mid-pulse
        bus.mode = 1'b0;
        bus.lo = 5'd3;
        tick();
        bus.a[2] = 1'b1;
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        chk("t5_async_s", 32'(bus.s), 0);
        chk("t5_async_ovf", 32'(bus.ovf), 0);
        chk("t5_async_len", 32'(bus.len_o), 0);
        #1 rst = 1'b0;
        bus.a[2] = 1'b0;
        tick();
        pulse(2, 3);
        chk("t5_post_strobe", 32'(bus.s), 32'h4);
        chk("t5_post_len", len_of(2), 3);

        // Mode change mid-pulse keeps ovf and len, restarts the count
        pulse(1, 32);
        chk("t6_ovf1", 32'(bus.ovf), 32'h2);
        pulse(0, 2);
        chk("t6_len0_pre", len_of(0), 2);
        bus.a[0] = 1'b1;
        repeat (3) tick();
        bus.mode = 1'b1;
        bus.lo = 5'd4;
        tick();
        chk("t6_chg_s", 32'(bus.s), 0);
        chk("t6_chg_ovf", 32'(bus.ovf), 32'h2);
        chk("t6_chg_len0", len_of(0), 2);
        chk("t6_chg_len1", len_of(1), 31);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("t6_deb_%0d", k), 32'(bus.s[0]), (k == 4) ? 32'h1 : 32'h0);
        end
        bus.a[0] = 1'b0;
        tick();
        chk("t6_fall_s", 32'(bus.s), 0);
        chk("t6_fall_len", len_of(0), 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
